// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM access arbiter.
//   - sram_state_e : access sequencer states
//   - owner_e      : which requester owns the current access
//   - acc_req_t    : one latched access (address, direction, lanes, data)
//   - block_cs_l() : 64 KB block select decode, one-hot active low
package sram_pkg;

  localparam int SRAM_WORD_AW  = 17;
  localparam int SRAM_BLOCK_AW = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_CPU_HOLD
  } sram_state_e;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_e;

  typedef struct packed {
    logic [SRAM_WORD_AW-1:0] addr;
    logic                    rw;     // 1 = read
    logic [1:0]              be;     // [1] upper, [0] lower, active high
    logic [15:0]             wdata;
  } acc_req_t;

  function automatic logic [3:0] block_cs_l(input logic [1:0] blk);
    return ~(4'b0001 << blk);
  endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin grant between CPU and DMA.
//   i_cpu_req, i_dma_req : request levels
//   i_last_grant         : owner of the previous grant
//   o_grant              : one-hot grant, [0] = CPU, [1] = DMA (0 when idle)
// Purely combinational; the sequencer only samples it in IDLE.
module sram_rr_arbiter
  import sram_pkg::*;
(
  input  logic       i_cpu_req,
  input  logic       i_dma_req,
  input  owner_e     i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    if (i_cpu_req && i_dma_req)
      o_grant = (i_last_grant == OWNER_DMA) ? 2'b01 : 2'b10;
    else if (i_cpu_req)
      o_grant = 2'b01;
    else if (i_dma_req)
      o_grant = 2'b10;
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// Sequences all accesses to the 128 K-word SRAM and shares it between the
// 68k CPU (DTACK handshake) and a DMA/video port (one-cycle ack).
//   CPU side : CpuReq_H, CpuRW, CpuUDS_L/CpuLDS_L, CpuAddress, CpuDataIn,
//              CpuDataOut, CpuDtack_L
//   DMA side : DmaReq_H, DmaRW, DmaByteEn, DmaAddress, DmaDataIn,
//              DmaDataOut, DmaAck_H
//   SRAM     : SramAddress, SramBlockCS_L, SramOE_L, SramWE_L, SramUB_L,
//              SramLB_L, SramDataOut, SramDataOutEn_H, SramDataIn
// Every output is a flop loaded with the value for the state being entered,
// so nothing combinational reaches the SRAM pins.
module sram_access_arbiter
  import sram_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic                     Clock,
  input  logic                     Reset_L,
  input  logic                     CpuReq_H,
  input  logic                     CpuRW,
  input  logic                     CpuUDS_L,
  input  logic                     CpuLDS_L,
  input  logic [SRAM_WORD_AW-1:0]  CpuAddress,
  input  logic [15:0]              CpuDataIn,
  output logic [15:0]              CpuDataOut,
  output logic                     CpuDtack_L,
  input  logic                     DmaReq_H,
  input  logic                     DmaRW,
  input  logic [1:0]               DmaByteEn,
  input  logic [SRAM_WORD_AW-1:0]  DmaAddress,
  input  logic [15:0]              DmaDataIn,
  output logic [15:0]              DmaDataOut,
  output logic                     DmaAck_H,
  output logic [SRAM_BLOCK_AW-1:0] SramAddress,
  output logic [3:0]               SramBlockCS_L,
  output logic                     SramOE_L,
  output logic                     SramWE_L,
  output logic                     SramUB_L,
  output logic                     SramLB_L,
  output logic [15:0]              SramDataOut,
  output logic                     SramDataOutEn_H,
  input  logic [15:0]              SramDataIn
);

  localparam logic [2:0] LP_WLAST = 3'(WAIT_STATES);

  sram_state_e r_state;
  owner_e      r_owner;
  owner_e      r_last_grant;
  logic        r_rw;
  logic        r_abort;
  logic [2:0]  r_wcnt;
  logic [1:0]  w_grant;
  acc_req_t    w_win;

  sram_rr_arbiter u_arb (
    .i_cpu_req    (CpuReq_H),
    .i_dma_req    (DmaReq_H),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  // Winner's request, only meaningful while a grant is present.
  always_comb begin
    w_win = '{addr: CpuAddress, rw: CpuRW, be: {~CpuUDS_L, ~CpuLDS_L}, wdata: CpuDataIn};
    if (w_grant[1])
      w_win = '{addr: DmaAddress, rw: DmaRW, be: DmaByteEn, wdata: DmaDataIn};
  end

  // The SRAM pin registers (address, CS, lanes, write data) double as the
  // access register; only the direction is kept separately.
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state         <= ST_IDLE;
      r_owner         <= OWNER_CPU;
      r_last_grant    <= OWNER_DMA;
      r_rw            <= 1'b1;
      r_abort         <= 1'b0;
      r_wcnt          <= '0;
      CpuDataOut      <= '0;
      CpuDtack_L      <= 1'b1;
      DmaDataOut      <= '0;
      DmaAck_H        <= 1'b0;
      SramAddress     <= '0;
      SramBlockCS_L   <= 4'hF;
      SramOE_L        <= 1'b1;
      SramWE_L        <= 1'b1;
      SramUB_L        <= 1'b1;
      SramLB_L        <= 1'b1;
      SramDataOut     <= '0;
      SramDataOutEn_H <= 1'b0;
    end else begin
      DmaAck_H <= 1'b0;
      // A CPU that ends its bus cycle mid-access loses its DTACK, but the
      // SRAM cycle itself always runs to completion.
      if (r_owner == OWNER_CPU && !CpuReq_H &&
          (r_state == ST_SETUP || r_state == ST_ACCESS))
        r_abort <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (|w_grant) begin
            r_owner         <= w_grant[1] ? OWNER_DMA : OWNER_CPU;
            r_last_grant    <= w_grant[1] ? OWNER_DMA : OWNER_CPU;
            r_rw            <= w_win.rw;
            r_abort         <= 1'b0;
            SramAddress     <= w_win.addr[SRAM_BLOCK_AW-1:0];
            SramBlockCS_L   <= block_cs_l(w_win.addr[SRAM_WORD_AW-1:SRAM_BLOCK_AW]);
            SramUB_L        <= ~w_win.be[1];
            SramLB_L        <= ~w_win.be[0];
            SramOE_L        <= ~w_win.rw;
            SramDataOutEn_H <= ~w_win.rw;
            SramDataOut     <= w_win.wdata;
            r_state         <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_wcnt   <= '0;
          SramWE_L <= r_rw;
          r_state  <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (r_wcnt == LP_WLAST) begin
            // Raise WE one cycle before CS goes away; read data is sampled
            // here so it is already valid during DONE.
            SramWE_L <= 1'b1;
            if (r_rw) begin
              if (r_owner == OWNER_DMA) DmaDataOut <= SramDataIn;
              else                      CpuDataOut <= SramDataIn;
            end
            DmaAck_H <= (r_owner == OWNER_DMA);
            r_state  <= ST_DONE;
          end else begin
            r_wcnt <= r_wcnt + 3'd1;
          end
        end
        ST_DONE: begin
          SramBlockCS_L   <= 4'hF;
          SramOE_L        <= 1'b1;
          SramUB_L        <= 1'b1;
          SramLB_L        <= 1'b1;
          SramDataOutEn_H <= 1'b0;
          if (r_owner == OWNER_CPU && !r_abort && CpuReq_H) begin
            CpuDtack_L <= 1'b0;
            r_state    <= ST_CPU_HOLD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CPU_HOLD: begin
          if (!CpuReq_H) begin
            CpuDtack_L <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: SRAM model, scoreboard of expected grants
// in order, plus two extra instances (W=0, W=7) for the latency sweep.
module tb_sram_access_arbiter;

  logic        Clock = 1'b0;
  logic        Reset_L;
  logic        CpuReq_H, CpuRW, CpuUDS_L, CpuLDS_L;
  logic [16:0] CpuAddress;
  logic [15:0] CpuDataIn, CpuDataOut;
  logic        CpuDtack_L;
  logic        DmaReq_H, DmaRW;
  logic [1:0]  DmaByteEn;
  logic [16:0] DmaAddress;
  logic [15:0] DmaDataIn, DmaDataOut;
  logic        DmaAck_H;
  logic [14:0] SramAddress;
  logic [3:0]  SramBlockCS_L;
  logic        SramOE_L, SramWE_L, SramUB_L, SramLB_L, SramDataOutEn_H;
  logic [15:0] SramDataOut, SramDataIn;

  always #5 Clock = ~Clock;

  sram_access_arbiter #(.WAIT_STATES(1)) dut (
    .Clock(Clock), .Reset_L(Reset_L),
    .CpuReq_H(CpuReq_H), .CpuRW(CpuRW), .CpuUDS_L(CpuUDS_L), .CpuLDS_L(CpuLDS_L),
    .CpuAddress(CpuAddress), .CpuDataIn(CpuDataIn), .CpuDataOut(CpuDataOut),
    .CpuDtack_L(CpuDtack_L),
    .DmaReq_H(DmaReq_H), .DmaRW(DmaRW), .DmaByteEn(DmaByteEn), .DmaAddress(DmaAddress),
    .DmaDataIn(DmaDataIn), .DmaDataOut(DmaDataOut), .DmaAck_H(DmaAck_H),
    .SramAddress(SramAddress), .SramBlockCS_L(SramBlockCS_L), .SramOE_L(SramOE_L),
    .SramWE_L(SramWE_L), .SramUB_L(SramUB_L), .SramLB_L(SramLB_L),
    .SramDataOut(SramDataOut), .SramDataOutEn_H(SramDataOutEn_H), .SramDataIn(SramDataIn)
  );

  // Sweep instances: DMA only, fixed read data.
  logic        sw_cpu_req = 1'b0;
  logic        sw_req0, sw_req7;
  logic [15:0] sw_din = 16'hA5C3;
  logic [15:0] s0_cdo, s0_ddo, s0_sdo, s7_cdo, s7_ddo, s7_sdo;
  logic        s0_dtk, s0_ack, s0_oe, s0_we, s0_ub, s0_lb, s0_en;
  logic        s7_dtk, s7_ack, s7_oe, s7_we, s7_ub, s7_lb, s7_en;
  logic [14:0] s0_sa, s7_sa;
  logic [3:0]  s0_cs, s7_cs;

  sram_access_arbiter #(.WAIT_STATES(0)) u_w0 (
    .Clock(Clock), .Reset_L(Reset_L),
    .CpuReq_H(sw_cpu_req), .CpuRW(CpuRW), .CpuUDS_L(CpuUDS_L), .CpuLDS_L(CpuLDS_L),
    .CpuAddress(CpuAddress), .CpuDataIn(CpuDataIn), .CpuDataOut(s0_cdo), .CpuDtack_L(s0_dtk),
    .DmaReq_H(sw_req0), .DmaRW(DmaRW), .DmaByteEn(DmaByteEn), .DmaAddress(DmaAddress),
    .DmaDataIn(DmaDataIn), .DmaDataOut(s0_ddo), .DmaAck_H(s0_ack),
    .SramAddress(s0_sa), .SramBlockCS_L(s0_cs), .SramOE_L(s0_oe), .SramWE_L(s0_we),
    .SramUB_L(s0_ub), .SramLB_L(s0_lb), .SramDataOut(s0_sdo), .SramDataOutEn_H(s0_en),
    .SramDataIn(sw_din)
  );

  sram_access_arbiter #(.WAIT_STATES(7)) u_w7 (
    .Clock(Clock), .Reset_L(Reset_L),
    .CpuReq_H(sw_cpu_req), .CpuRW(CpuRW), .CpuUDS_L(CpuUDS_L), .CpuLDS_L(CpuLDS_L),
    .CpuAddress(CpuAddress), .CpuDataIn(CpuDataIn), .CpuDataOut(s7_cdo), .CpuDtack_L(s7_dtk),
    .DmaReq_H(sw_req7), .DmaRW(DmaRW), .DmaByteEn(DmaByteEn), .DmaAddress(DmaAddress),
    .DmaDataIn(DmaDataIn), .DmaDataOut(s7_ddo), .DmaAck_H(s7_ack),
    .SramAddress(s7_sa), .SramBlockCS_L(s7_cs), .SramOE_L(s7_oe), .SramWE_L(s7_we),
    .SramUB_L(s7_ub), .SramLB_L(s7_lb), .SramDataOut(s7_sdo), .SramDataOutEn_H(s7_en),
    .SramDataIn(sw_din)
  );

  // ---------------- SRAM model ----------------
  logic [15:0] mem [0:131071];

  function automatic logic [1:0] blk_of(input logic [3:0] cs);
    case (cs)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  assign SramDataIn = (!SramOE_L && SramBlockCS_L != 4'hF) ?
                      mem[{blk_of(SramBlockCS_L), SramAddress}] : 16'h0000;

  initial forever begin
    @(posedge Clock);
    if (!SramWE_L && SramBlockCS_L != 4'hF) begin
      if (!SramUB_L) mem[{blk_of(SramBlockCS_L), SramAddress}][15:8] <= SramDataOut[15:8];
      if (!SramLB_L) mem[{blk_of(SramBlockCS_L), SramAddress}][7:0]  <= SramDataOut[7:0];
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        dma;
    logic        rw;
    logic [15:0] rdata;
  } exp_t;
  exp_t sbq[$];

  task automatic push(input logic dma, input logic rw, input logic [16:0] a);
    exp_t e;
    e.dma = dma; e.rw = rw; e.rdata = mem[a];
    sbq.push_back(e);
  endtask

  int cyc = 0;
  initial forever begin @(posedge Clock); cyc++; end

  // Monitor: protocol, pin observation, scoreboard pops.
  int          ack_cnt = 0, dtk_cnt = 0, we_run = 0, we_len = 0;
  logic [3:0]  cs_seen = 4'hF;
  logic        ub_seen = 1'b1, lb_seen = 1'b1, dtk_q = 1'b1, hold_rd = 1'b0;
  logic [15:0] hold_exp = '0;

  initial forever begin
    exp_t e;
    @(negedge Clock);
    if (!SramWE_L) begin
      chk("we_in_cs", {31'd0, SramBlockCS_L != 4'hF}, 32'd1);
      we_run++;
    end else if (we_run != 0) begin
      we_len = we_run;
      we_run = 0;
    end
    if (SramBlockCS_L != 4'hF) begin
      cs_seen = SramBlockCS_L; ub_seen = SramUB_L; lb_seen = SramLB_L;
    end
    if (DmaAck_H) begin
      ack_cnt++;
      if (sbq.size() == 0) chk("sb_unexpected_ack", 0, 1);
      else begin
        e = sbq.pop_front();
        chk("sb_owner_dma", {31'd0, e.dma}, 32'd1);
        if (e.rw) chk("sb_dma_rdata", DmaDataOut, e.rdata);
      end
    end
    if (!CpuDtack_L && dtk_q) begin
      dtk_cnt++;
      hold_rd = 1'b0;
      if (sbq.size() == 0) chk("sb_unexpected_dtack", 0, 1);
      else begin
        e = sbq.pop_front();
        chk("sb_owner_cpu", {31'd0, e.dma}, 32'd0);
        if (e.rw) begin
          chk("sb_cpu_rdata", CpuDataOut, e.rdata);
          hold_rd = 1'b1; hold_exp = e.rdata;
        end
      end
    end else if (!CpuDtack_L && hold_rd) begin
      chk("cpu_hold_data", CpuDataOut, hold_exp);
    end
    dtk_q = CpuDtack_L;
  end

  // ---------------- agents ----------------
  task automatic cpu_cycle(input logic rw, input logic [16:0] a, input logic [15:0] wd,
                           input logic [1:0] strb_l, output int lat);
    int t0;
    t0 = cyc; lat = -1;
    CpuRW = rw; CpuAddress = a; CpuDataIn = wd; {CpuUDS_L, CpuLDS_L} = strb_l;
    CpuReq_H = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clock);
      if (!CpuDtack_L) begin lat = cyc - t0; break; end
    end
    CpuReq_H = 1'b0;
    if (lat < 0) chk("cpu_dtack_timeout", 0, 1);
  endtask

  task automatic dma_xfer(input logic rw, input logic [1:0] be, input logic [16:0] a,
                          input logic [15:0] wd, output int lat);
    int t0;
    t0 = cyc; lat = -1;
    DmaRW = rw; DmaByteEn = be; DmaAddress = a; DmaDataIn = wd;
    DmaReq_H = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clock);
      if (DmaAck_H) begin lat = cyc - t0; break; end
    end
    DmaReq_H = 1'b0;
    if (lat < 0) chk("dma_ack_timeout", 0, 1);
  endtask

  task automatic rst_pulse();
    @(negedge Clock);
    Reset_L = 1'b0; CpuReq_H = 1'b0; DmaReq_H = 1'b0;
    repeat (2) @(negedge Clock);
    Reset_L = 1'b1;
    @(negedge Clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- sequence ----------------
  initial begin
    int l0, l1, l2, l3, a0, d0, t0, s0n;
    Reset_L = 1'b0;
    CpuReq_H = 0; CpuRW = 1; CpuUDS_L = 1; CpuLDS_L = 1; CpuAddress = '0; CpuDataIn = '0;
    DmaReq_H = 0; DmaRW = 1; DmaByteEn = '0; DmaAddress = '0; DmaDataIn = '0;
    sw_req0 = 0; sw_req7 = 0;
    mem[17'h08000] = 16'hBEEF; mem[17'h1FFFF] = 16'h5566;
    mem[17'h00010] = 16'h1111; mem[17'h10020] = 16'h2222;
    mem[17'h00011] = 16'h3333; mem[17'h10021] = 16'h4444;
    mem[17'h18000] = 16'h5555; mem[17'h0C123] = 16'h6789;
    repeat (3) @(negedge Clock);
    Reset_L = 1'b1;
    @(negedge Clock);

    // reset state
    chk("rst_cs", SramBlockCS_L, 4'hF);
    chk("rst_ctl", {SramOE_L, SramWE_L, SramUB_L, SramLB_L, CpuDtack_L}, 5'b11111);
    chk("rst_ack_en", {DmaAck_H, SramDataOutEn_H}, 2'b00);
    chk("rst_dout", {CpuDataOut, DmaDataOut}, 32'h0);
    chk("rst_sram_ad", {SramAddress, SramDataOut}, 31'h0);

    // CPU read, block 1
    push(1'b0, 1'b1, 17'h08000);
    cpu_cycle(1'b1, 17'h08000, 16'h0, 2'b00, l0);
    chk("cpu_rd_lat", l0, 5);
    chk("cpu_rd_cs", cs_seen, 4'b1101);
    chk("cpu_rd_data", CpuDataOut, 16'hBEEF);
    @(negedge Clock);
    chk("cpu_rel_dtack", CpuDtack_L, 1'b1);
    chk("cpu_rel_cs", SramBlockCS_L, 4'hF);

    // DMA upper-byte write, straight from the IDLE that follows the release
    a0 = ack_cnt;
    push(1'b1, 1'b0, 17'h1FFFF);
    dma_xfer(1'b0, 2'b10, 17'h1FFFF, 16'h12AB, l0);
    chk("dma_wr_lat", l0, 4);
    chk("dma_wr_cs", cs_seen, 4'b0111);
    chk("dma_wr_lanes", {ub_seen, lb_seen}, 2'b01);
    repeat (3) @(negedge Clock);
    chk("dma_wr_we_len", we_len, 2);
    chk("dma_wr_acks", ack_cnt - a0, 1);
    chk("dma_wr_mem", mem[17'h1FFFF], 16'h1266);

    // contention from a fresh reset: CPU, DMA, CPU, DMA
    rst_pulse();
    push(1'b0, 1'b1, 17'h00010); push(1'b1, 1'b1, 17'h10020);
    push(1'b0, 1'b1, 17'h00011); push(1'b1, 1'b1, 17'h10021);
    fork
      begin
        cpu_cycle(1'b1, 17'h00010, 16'h0, 2'b00, l0);
        @(negedge Clock);
        cpu_cycle(1'b1, 17'h00011, 16'h0, 2'b00, l1);
      end
      begin
        dma_xfer(1'b1, 2'b11, 17'h10020, 16'h0, l2);
        @(negedge Clock);
        dma_xfer(1'b1, 2'b11, 17'h10021, 16'h0, l3);
      end
    join
    chk("rr_cpu_first_lat", l0, 5);
    chk("rr_dma_second_lat", l2, 10);
    repeat (2) @(negedge Clock);
    chk("rr_sb_drained", sbq.size(), 0);

    // CPU abort during ACCESS with DMA pending
    rst_pulse();
    d0 = dtk_cnt;
    push(1'b1, 1'b1, 17'h18000);
    fork
      begin
        CpuRW = 1'b1; CpuAddress = 17'h00012; {CpuUDS_L, CpuLDS_L} = 2'b00;
        CpuReq_H = 1'b1;
        repeat (2) @(negedge Clock);
        CpuReq_H = 1'b0;
      end
      dma_xfer(1'b1, 2'b11, 17'h18000, 16'h0, l0);
    join
    chk("abort_dma_lat", l0, 9);
    repeat (3) @(negedge Clock);
    chk("abort_no_dtack", dtk_cnt - d0, 0);

    // async reset during ACCESS of a write
    DmaRW = 1'b0; DmaByteEn = 2'b01; DmaAddress = 17'h04000; DmaDataIn = 16'h9999;
    DmaReq_H = 1'b1;
    repeat (2) @(negedge Clock);
    chk("rst_mid_we_low", SramWE_L, 1'b0);
    a0 = ack_cnt;
    #1 Reset_L = 1'b0; DmaReq_H = 1'b0;
    #1;
    chk("rst_mid_we", SramWE_L, 1'b1);
    chk("rst_mid_cs", SramBlockCS_L, 4'hF);
    chk("rst_mid_en", SramDataOutEn_H, 1'b0);
    @(negedge Clock);
    Reset_L = 1'b1;
    repeat (8) @(negedge Clock);
    chk("rst_mid_no_ack", ack_cnt - a0, 0);
    push(1'b1, 1'b1, 17'h0C123);
    dma_xfer(1'b1, 2'b11, 17'h0C123, 16'h0, l0);
    chk("rst_recover_lat", l0, 4);

    // wait-state sweep
    DmaRW = 1'b1; DmaByteEn = 2'b11; DmaAddress = 17'h00100;
    t0 = cyc; l0 = -1; l1 = -1; s0n = 0;
    sw_req0 = 1'b1; sw_req7 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clock);
      if (s0_ack) s0n++;
      if (s0_ack && l0 < 0) begin
        l0 = cyc - t0; sw_req0 = 1'b0;
        chk("w0_rdata", s0_ddo, 16'hA5C3);
      end
      if (s7_ack && l1 < 0) begin
        l1 = cyc - t0; sw_req7 = 1'b0;
        chk("w7_rdata", s7_ddo, 16'hA5C3);
      end
    end
    sw_req0 = 1'b0; sw_req7 = 1'b0;
    chk("w0_ack_lat", l0, 3);
    chk("w7_ack_lat", l1, 10);
    chk("w0_single_ack", s0n, 1);
    chk("sb_final_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
